// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default sizes,
// FSM state encoding and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [WIDTH_DEF-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_seq_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the sequential divider (slave).
interface div_seq_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [WIDTH-1:0] zlow;
  logic [WIDTH-1:0] zhigh;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, regA, regB,
    input  zlow, zhigh, busy, done, div_by_zero
  );

  modport slave (
    input  start, regA, regB,
    output zlow, zhigh, busy, done, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 non-restoring division step on magnitudes.
// {P,Q} is shifted left one place, then D is subtracted when the old
// partial remainder was non-negative or added when it was negative.
// The new quotient bit is the inverted sign of the resulting P.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   p_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   p_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] p_shift;
  logic [WIDTH:0] d_ext;

  // The top bit of P can be dropped on the shift: |P| < D <= 2^(WIDTH-1)
  // keeps 2P inside the signed WIDTH+1 range.
  assign p_shift = {p_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign d_ext   = {1'b0, d_i};
  assign p_o     = p_i[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
  assign q_o     = {q_i[WIDTH-2:0], ~p_o[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed WIDTH/WIDTH divider with start/busy/done handshake.
// Quotient goes to zlow, remainder to zhigh. Fixed latency: done is high
// in the 34th cycle after the accepted start edge (WIDTH=32).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic      clock,
  input  logic      clear,
  div_seq_if.slave  bus
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH:0]   p_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] a_raw_q;
  logic             sign_q_q;
  logic             sign_r_q;
  logic             dbz_q;
  logic [WIDTH-1:0] zlow_q;
  logic [WIDTH-1:0] zhigh_q;
  logic             dbz_out_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] a_abs_d;
  logic [WIDTH-1:0] b_abs_d;
  logic [WIDTH:0]   p_step_d;
  logic [WIDTH-1:0] q_step_d;
  logic [WIDTH:0]   p_fix_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] rem_d;

  // Magnitudes are unsigned WIDTH bits, so |0x80000000| = 0x80000000 as-is.
  assign a_abs_d = bus.regA[WIDTH-1] ? -bus.regA : bus.regA;
  assign b_abs_d = bus.regB[WIDTH-1] ? -bus.regB : bus.regB;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p_i (p_q),
    .q_i (q_q),
    .d_i (d_q),
    .p_o (p_step_d),
    .q_o (q_step_d)
  );

  // Final remainder correction, sign application and divide-by-zero override.
  always_comb begin
    p_fix_d = p_q[WIDTH] ? (p_q + {1'b0, d_q}) : p_q;
    quo_d   = sign_q_q ? -q_q : q_q;
    rem_d   = sign_r_q ? -p_fix_d[WIDTH-1:0] : p_fix_d[WIDTH-1:0];
    if (dbz_q) begin
      quo_d = DIV0_QUOTIENT;
      rem_d = a_raw_q;
    end
  end

  // Control FSM, iteration datapath and registered result/handshake outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      count_q   <= '0;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      a_raw_q   <= '0;
      sign_q_q  <= 1'b0;
      sign_r_q  <= 1'b0;
      dbz_q     <= 1'b0;
      zlow_q    <= '0;
      zhigh_q   <= '0;
      dbz_out_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            q_q      <= a_abs_d;
            d_q      <= b_abs_d;
            a_raw_q  <= bus.regA;
            sign_q_q <= bus.regA[WIDTH-1] ^ bus.regB[WIDTH-1];
            sign_r_q <= bus.regA[WIDTH-1];
            dbz_q    <= (bus.regB == '0);
            p_q      <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ITER;
          end
        end
        ITER: begin
          p_q     <= p_step_d;
          q_q     <= q_step_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          p_q       <= p_fix_d;
          zlow_q    <= quo_d;
          zhigh_q   <= rem_d;
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.zlow        = zlow_q;
  assign bus.zhigh       = zhigh_q;
  assign bus.div_by_zero = dbz_out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle signed 32/32 divider for the datapath ALU.
- Consumes the same A/B operand buses as the combinational bitwise ops.
- Produces the 64-bit Z result pair: quotient to zlow, remainder to zhigh.
- Uses a start/busy/done handshake so the control unit can stall the DIV instruction until the result is ready.
- Implemented as radix-2 non-restoring division on magnitudes, with a sign fixup at the end.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
clock  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
regA  input  WIDTH  dividend, two's complement
regB  input  WIDTH  divisor, two's complement
zlow  output  WIDTH  quotient
zhigh  output  WIDTH  remainder
busy  output  1  high from the cycle after start is accepted through the done cycle
done  output  1  one-cycle pulse; zlow/zhigh valid from this cycle on
div_by_zero  output  1  set with done when regB was 0; held with the result

Behaviour:
- Reset: clear high at a rising edge →
  - state=IDLE;
  - zlow, zhigh, busy, done, div_by_zero all 0;
  - internal accumulator and counter cleared.
  - clear takes priority over every other input, including mid-operation: any division in progress is aborted and no done is produced.
- States: IDLE → ITER → FIX → DONE → IDLE.
- IDLE:
  - On an edge E0 with start=1, capture regA and regB, then latch:
    - |A| into the quotient shift register;
    - |B| into the divisor register;
    - sign_q = A[31] xor B[31];
    - sign_r = A[31];
    - dbz = (B==0).
  - Partial remainder P (WIDTH+1 bits) = 0; count=0; go to ITER.
  - start=0 → stay in IDLE; outputs hold their last values.
- ITER: one non-restoring step per edge, 32 edges (E1..E32).
  - If P>=0: shift {P,Q} left, then P = P - D. Else: shift left, then P = P + D.
  - New Q[0] = ~P[WIDTH].
  - count increments; after the step with count==WIDTH-1, go to FIX.
- FIX (edge E33):
  - If P<0, then P = P + D.
  - Apply signs:
    - quotient = sign_q ? -Q : Q;
    - remainder = sign_r ? -P : P (truncated to WIDTH bits).
  - Rounding is truncation toward zero; the remainder takes the sign of the dividend.
  - If dbz: quotient = all ones (0xFFFFFFFF) and remainder = original regA, both unsigned-raw.
  - Register zlow, zhigh and div_by_zero. Go to DONE.
- DONE: done=1 for exactly this cycle (the one following E33), busy=1. On the next edge, return to IDLE with done=0 and busy=0.
- Latency: done is high in the 34th cycle after the start edge. It is fixed and data-independent, including the divide-by-zero case.
- busy: 1 in ITER, FIX and DONE; 0 in IDLE.
- start while busy: ignored; it is not queued. regA/regB may change freely after E0.
- start in the DONE cycle: ignored. A new start is accepted only from IDLE, i.e. one cycle after done at the earliest.
- Overflow: 0x80000000 / 0xFFFFFFFF → zlow=0x80000000, zhigh=0, div_by_zero=0 (two's-complement wrap, no flag).
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned WIDTH bits. P is WIDTH+1 bits, so this is handled without special-casing.
- zlow, zhigh and div_by_zero change only at the FIX edge or on clear.

Decomposition:
- Package div_pkg holds:
  - WIDTH default;
  - state enum {IDLE, ITER, FIX, DONE} as 2-bit encoding;
  - DIV0_QUOTIENT constant = all ones.
- Sub-module div_step (combinational): inputs P, Q, D; outputs next P and next Q for one non-restoring step. Instantiated once in the ITER datapath.
- FSM, counter, sign logic and output registers stay in div_seq.

Test Plan:
1. regA=100, regB=7, start pulse → done 34 cycles later; zlow=14, zhigh=2, div_by_zero=0; busy high for 34 cycles.
2. regA=-100 (0xFFFFFF9C), regB=7 → zlow=0xFFFFFFF2 (-14), zhigh=0xFFFFFFFE (-2). Also run 100/-7 → zlow=-14, zhigh=2.
3. regA=5, regB=0 → zlow=0xFFFFFFFF, zhigh=5, div_by_zero=1, same latency. A following 9/3 → div_by_zero=0, zlow=3, zhigh=0.
4. regA=0x80000000, regB=0xFFFFFFFF → zlow=0x80000000, zhigh=0, no flag. Also 0x80000000/1 → zlow=0x80000000, zhigh=0.
5. Start 100/7; assert start again with different operands at cycles 5 and 34 (the DONE cycle) → both ignored; single done, result 14/2. Start accepted next cycle in IDLE.
6. Start 100/7, assert clear at cycle 10 → next cycle busy=0, done=0, zlow=zhigh=0, state IDLE, no done pulse later. A new start gives a correct result.
